// File: rtl/reg_file_pkg.sv
// Shared register-file constants and types, reused by decode and write-back.
package reg_file_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_word.sv
// One storage word with a synchronous active-low clear and a load enable.
module reg_word #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] word_q;

  // Clear takes priority so an unknown load cannot disturb a reset cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_q <= '0;
    end else if (load_i) begin
      word_q <= d_i;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/reg_file.sv
// 2**ADDR_W x DATA_W register file: one synchronous write port, two combinational read ports.
module reg_file #(
  parameter int unsigned DATA_W = reg_file_pkg::DATA_W,
  parameter int unsigned ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sto,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] databus1,
  output logic [DATA_W-1:0] databus2
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [NumRegs-1:0] load;
  logic [DATA_W-1:0]  word [NumRegs];

  always_comb begin
    load = '0;
    if (sto) begin
      load[waddr] = 1'b1;
    end
  end

  for (genvar i = 0; i < NumRegs; i++) begin : g_word
    reg_word #(
      .Width (DATA_W)
    ) u_word (
      .clk_i  (clk),
      .rst_ni (rst),
      .load_i (load[i]),
      .d_i    (dataIn),
      .q_o    (word[i])
    );
  end

  // No write bypass: reads see the stored value only.
  assign databus1 = word[raddr1];
  assign databus2 = word[raddr2];

endmodule

// File: tb/tb_reg_file.sv
// Randomised and directed bench with a scoreboard and an array reference model.
module tb_reg_file;
  import reg_file_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      sto;
  reg_addr_t waddr;
  reg_data_t dataIn;
  reg_addr_t raddr1;
  reg_addr_t raddr2;
  reg_data_t databus1;
  reg_data_t databus2;

  int total = 0;
  int bad   = 0;

  reg_data_t model [NUM_REGS];
  reg_data_t exp1_q [$];
  reg_data_t exp2_q [$];
  string     name_q [$];
  logic      rd_valid = 1'b0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk      (clk),
    .rst      (rst),
    .sto      (sto),
    .waddr    (waddr),
    .dataIn   (dataIn),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .databus1 (databus1),
    .databus2 (databus2)
  );

  // Advance one edge; the model applies the same rules to the inputs present at the edge.
  task automatic step();
    @(posedge clk);
    if (rst == 1'b0) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    end else if (sto === 1'b1) begin
      model[waddr] = dataIn;
    end
    #1;
  endtask

  task automatic rd(input reg_addr_t a1, input reg_addr_t a2, input string nm);
    raddr1 = a1;
    raddr2 = a2;
    exp1_q.push_back(model[a1]);
    exp2_q.push_back(model[a2]);
    name_q.push_back(nm);
    rd_valid = 1'b1;
    @(negedge clk);
    #1;
    rd_valid = 1'b0;
  endtask

  task automatic wr(input reg_addr_t a, input reg_data_t d);
    sto    = 1'b1;
    waddr  = a;
    dataIn = d;
    step();
    sto = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Monitor: compare whenever the driver flags a read as presented.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp1_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: read presented with no expected entry");
      end else begin
        reg_data_t e1, e2;
        string nm;
        e1 = exp1_q.pop_front();
        e2 = exp2_q.pop_front();
        nm = name_q.pop_front();
        total++;
        if (databus1 !== e1) begin
          bad++;
          $display("FAIL %s bus1: got %h want %h", nm, databus1, e1);
        end
        total++;
        if (databus2 !== e2) begin
          bad++;
          $display("FAIL %s bus2: got %h want %h", nm, databus2, e2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sto = 1'b0; waddr = '0; dataIn = '0; raddr1 = '0; raddr2 = '0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    @(posedge clk); #1;

    // Reset clear after a preload.
    wr(3'd3, 32'h1111_1111);
    rd(3'd3, 3'd3, "preload");
    do_reset();
    rd(3'd3, 3'd7, "reset_clear");

    // Register 0 is ordinary storage.
    wr(3'd0, 32'hABCD_1234);
    rd(3'd0, 3'd0, "reg0");

    // Every register through both ports.
    for (int i = 0; i < NUM_REGS; i++) wr(reg_addr_t'(i), 32'h1000_0000 + i);
    for (int i = 0; i < NUM_REGS; i++) rd(reg_addr_t'(i), reg_addr_t'(7 - i), "sweep");

    // Write enable low holds state.
    wr(3'd5, 32'h5555_5555);
    waddr = 3'd5; dataIn = 32'hDEAD_BEEF;
    repeat (3) step();
    rd(3'd5, 3'd0, "sto_low");

    // No bypass: old value before the edge, new after.
    do_reset();
    sto = 1'b1; waddr = 3'd2; dataIn = 32'hCAFE_F00D;
    rd(3'd2, 3'd2, "no_bypass_pre");
    step();
    sto = 1'b0;
    rd(3'd2, 3'd1, "no_bypass_post");

    // Reset beats a simultaneous write.
    wr(3'd4, 32'h0404_0404);
    rst = 1'b0; sto = 1'b1; waddr = 3'd4; dataIn = 32'hFFFF_FFFF;
    step();
    rst = 1'b1; sto = 1'b0;
    rd(3'd0, 3'd4, "reset_wins");

    // Back-to-back writes to one address, each visible for its cycle.
    for (int i = 0; i < 4; i++) begin
      sto = 1'b1; waddr = 3'd6; dataIn = 32'h6000_0000 + i;
      step();
      rd(3'd6, 3'd6, "b2b");
    end
    sto = 1'b0;

    // Reset with unknown write controls.
    wr(3'd1, 32'h1234_5678);
    rst = 1'b0; sto = 1'bx; waddr = 'x;
    step();
    rst = 1'b1; sto = 1'b0; waddr = '0;
    rd(3'd1, 3'd7, "reset_x_ctrl");

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      rst    = ($urandom_range(0, 31) != 0);
      sto    = 1'($urandom_range(0, 1));
      waddr  = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      dataIn = $urandom;
      rd(reg_addr_t'($urandom_range(0, NUM_REGS - 1)),
         reg_addr_t'($urandom_range(0, NUM_REGS - 1)), "rand_pre");
      step();
    end
    rst = 1'b1; sto = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) rd(reg_addr_t'(i), reg_addr_t'(NUM_REGS - 1 - i), "final");

    step();
    total++;
    if (exp1_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", exp1_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Eight-entry, 32-bit general-purpose register file for the Harvard MIPS datapath. It provides one synchronous write port and two independent asynchronous read ports. The decode stage uses it to fetch two source operands, and write-back uses it to store results.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 3, address width; register count is 2**ADDR_W (8)

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset; sampled on rising clk edge
- sto  in  1  write enable; high stores dataIn on the next rising edge
- waddr  in  ADDR_W  write register index
- dataIn  in  DATA_W  write data
- raddr1  in  ADDR_W  read port 1 register index
- raddr2  in  ADDR_W  read port 2 register index
- databus1  out  DATA_W  contents of register raddr1
- databus2  out  DATA_W  contents of register raddr2

## Operation
- Storage is 2**ADDR_W registers of DATA_W bits each. All registers are writable, including register 0; there is no hard-wired zero.
- Reset: on a rising edge with rst=0, every register is cleared to 0. Reset has priority over sto, so a write in the same cycle is discarded.
- Write: on a rising edge with rst=1 and sto=1, reg[waddr] is set to dataIn. All other registers hold their values.
- With sto=0, no register changes, regardless of waddr and dataIn.
- Read: databus1 = reg[raddr1] and databus2 = reg[raddr2], both purely combinational.
  - Both ports may address the same register.
  - Either port may address the register being written.
- No write-to-read bypass. A read of the register being written returns the old value until the edge, then the new value.
- Unknown (X) on sto or waddr must not corrupt state while rst=0. Reset behaviour is independent of the other inputs.

## Timing
- Write latency: one clock. Data becomes visible on the read buses combinationally after the rising edge that captures it.
- Read latency: zero cycles; output is a combinational function of raddrN and the current register contents.
- Reset latency: one clock. Both buses read 0 for any address after the first rising edge with rst=0.
- Before the first reset, register contents are undefined; the bench must not rely on them.
- Simultaneous reset and write: reset wins, and the register reads 0 afterwards.
- Back-to-back writes to the same address on consecutive edges: the last write wins, and each value is visible for one cycle.
- No handshake and no stall; sto is a single-cycle strobe, and a new write may be issued on every edge.

## Structure
- Shared package `reg_file_pkg`:
  - constants DATA_W=32, ADDR_W=3, NUM_REGS=8
  - typedefs `reg_addr_t` (ADDR_W bits) and `reg_data_t` (DATA_W bits)
  - these are reused by decode and write-back
- Sub-module `reg_word`: one DATA_W register with sync active-low clear and load enable. It is instantiated NUM_REGS times, with the load enable driven by a one-hot decode of waddr gated by sto.
- Top level contains:
  - write-address decoder
  - NUM_REGS `reg_word` instances
  - two independent NUM_REGS:1 read multiplexers, one per bus

## Test plan
- Reset clear:
  - preload reg3=32'h1111_1111, drive rst=0 for one edge, then rst=1
  - read raddr1=3, raddr2=7 -> both buses 32'h0000_0000
- Write/read register 0:
  - after reset, sto=1, waddr=0, dataIn=32'hABCD1234 for one edge, then sto=0
  - raddr1=0, raddr2=0 -> both buses 32'hABCD1234
- All registers, both ports:
  - write reg i = 32'h1000_0000+i for i=0..7
  - sweep raddr1=i and raddr2=7-i -> each bus shows its own register's value
- Write enable low:
  - reg5=32'h5555_5555, then sto=0, waddr=5, dataIn=32'hDEAD_BEEF for 3 edges
  - raddr1=5 -> 32'h5555_5555
- No bypass:
  - raddr1=2 (holding 32'h0), sto=1, waddr=2, dataIn=32'hCAFE_F00D
  - databus1 = 32'h0 before the edge, 32'hCAFE_F00D after it
- Reset beats write:
  - rst=0 and sto=1, waddr=4, dataIn=32'hFFFF_FFFF on the same edge
  - raddr2=4 -> 32'h0000_0000
